// File: rtl/max7219_serial_ctrl.sv
// rtl/max7219_serial_ctrl.sv - MAX7219 init + six-digit BCD refresh serialiser
module max7219_serial_ctrl #(
    parameter int         CLK_DIV   = 2,
    parameter logic [3:0] INTENSITY = 4'h8
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_update,
    input  logic [23:0] i_bcd,
    output logic        o_serial_clk,
    output logic        o_serial_dout,
    output logic        o_serial_load,
    output logic        o_busy
);

    localparam int              HW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [HW-1:0]   HMAX = HW'(CLK_DIV - 1);

    typedef enum logic [2:0] {S_INIT, S_IDLE, S_SHIFT, S_LOAD, S_GAP} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [HW-1:0] hcnt;
    logic          phase;
    logic [3:0]    bit_cnt;
    logic [2:0]    frame_idx;
    logic          init_mode;
    logic          pending;
    logic [23:0]   snap;
    logic          period_end;
    logic          last_frame;
    logic          start_refresh;
    logic [3:0]    digit;
    logic [15:0]   frame_word;

    function automatic logic [7:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 8'h7E;
            4'd1:    seg7 = 8'h30;
            4'd2:    seg7 = 8'h6D;
            4'd3:    seg7 = 8'h79;
            4'd4:    seg7 = 8'h33;
            4'd5:    seg7 = 8'h5B;
            4'd6:    seg7 = 8'h5F;
            4'd7:    seg7 = 8'h70;
            4'd8:    seg7 = 8'h7F;
            4'd9:    seg7 = 8'h7B;
            default: seg7 = 8'h00;
        endcase
    endfunction

    // Every SHIFT bit, LOAD and GAP is one "period": CLK_DIV low cycles then CLK_DIV high cycles.
    assign period_end    = phase && (hcnt == HMAX);
    assign last_frame    = init_mode ? (frame_idx == 3'd4) : (frame_idx == 3'd7);
    assign start_refresh = (state == S_IDLE) && (i_update || pending);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= S_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_INIT:  state_nxt = S_SHIFT;
            S_IDLE:  if (start_refresh) state_nxt = S_SHIFT;
            S_SHIFT: if (period_end && bit_cnt == 4'd0) state_nxt = S_LOAD;
            S_LOAD:  if (period_end) state_nxt = S_GAP;
            S_GAP:   if (period_end) state_nxt = last_frame ? S_IDLE : S_SHIFT;
            default: state_nxt = S_INIT;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            hcnt      <= '0;
            phase     <= 1'b0;
            bit_cnt   <= 4'd15;
            frame_idx <= 3'd0;
            init_mode <= 1'b1;
            pending   <= 1'b0;
            snap      <= '0;
        end else begin
            if (state == S_SHIFT || state == S_LOAD || state == S_GAP) begin
                if (hcnt == HMAX) begin
                    hcnt  <= '0;
                    phase <= ~phase;
                end else begin
                    hcnt <= hcnt + 1'b1;
                end
            end
            if (state == S_SHIFT && period_end && bit_cnt != 4'd0) begin
                bit_cnt <= bit_cnt - 4'd1;
            end
            if (state == S_GAP && period_end) begin
                bit_cnt <= 4'd15;
                if (!last_frame) begin
                    frame_idx <= frame_idx + 3'd1;
                end
            end
            // A strobe landing on the GAP->IDLE edge is still "busy" here, so it queues instead of being lost.
            if (start_refresh) begin
                pending   <= 1'b0;
                snap      <= i_bcd;
                frame_idx <= 3'd0;
                init_mode <= 1'b0;
                bit_cnt   <= 4'd15;
            end else if (i_update && state != S_IDLE) begin
                pending <= 1'b1;
            end
        end
    end

    always_comb begin
        case (frame_idx)
            3'd0:    digit = snap[23:20];
            3'd1:    digit = snap[19:16];
            3'd2:    digit = snap[15:12];
            3'd3:    digit = snap[11:8];
            3'd4:    digit = snap[7:4];
            3'd5:    digit = snap[3:0];
            default: digit = 4'hF;
        endcase
        if (init_mode) begin
            case (frame_idx)
                3'd0:    frame_word = 16'h0900;
                3'd1:    frame_word = {12'h0A0, INTENSITY};
                3'd2:    frame_word = 16'h0B07;
                3'd3:    frame_word = 16'h0C01;
                default: frame_word = 16'h0F00;
            endcase
        end else begin
            frame_word = {4'h0, {1'b0, frame_idx} + 4'd1, seg7(digit)};
        end
    end

    always_comb begin
        o_serial_clk  = (state == S_SHIFT) && phase;
        o_serial_dout = (state == S_SHIFT) && frame_word[bit_cnt];
        o_serial_load = (state == S_LOAD);
        o_busy        = (state != S_IDLE);
    end

endmodule

// File: tb/tb_max7219_serial_ctrl.sv
// tb/tb_max7219_serial_ctrl.sv - directed + random checks of max7219_serial_ctrl
module tb_max7219_serial_ctrl;

    localparam logic [7:0] SEG [0:15] = '{8'h7E, 8'h30, 8'h6D, 8'h79, 8'h33, 8'h5B, 8'h5F, 8'h70,
                                          8'h7F, 8'h7B, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

    logic        clk;
    logic        rst_n;
    logic        upd;
    logic        upd1;
    logic [23:0] bcd;
    logic [23:0] bcd1;
    logic [1:0]  sclk;
    logic [1:0]  dout;
    logic [1:0]  load;
    logic [1:0]  busy;

    int errors = 0;
    int checks = 0;

    max7219_serial_ctrl #(.CLK_DIV(2)) dut0 (
        .i_clk(clk), .i_reset_n(rst_n), .i_update(upd), .i_bcd(bcd),
        .o_serial_clk(sclk[0]), .o_serial_dout(dout[0]), .o_serial_load(load[0]), .o_busy(busy[0])
    );

    max7219_serial_ctrl #(.CLK_DIV(1)) dut1 (
        .i_clk(clk), .i_reset_n(rst_n), .i_update(upd1), .i_bcd(bcd1),
        .o_serial_clk(sclk[1]), .o_serial_dout(dout[1]), .o_serial_load(load[1]), .o_busy(busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pin-level monitor: rebuilds frames from CLK/DIN/LOAD and tallies timing violations.
    int          cyc = 0;
    int          nbits [2];
    int          last_rise [2];
    int          hi_start [2];
    int          ld_start [2];
    int          stab_err [2];
    int          per_err [2];
    int          hi_err [2];
    int          lw_err [2];
    int          ldclk_err [2];
    int          nbit_err [2];
    logic [15:0] shreg [2];
    logic        psclk [2];
    logic        pload [2];
    logic        pdout [2];
    logic [15:0] fq0 [$];
    logic [15:0] fq1 [$];
    int          lt0 [$];
    int          lt1 [$];
    logic [15:0] exp_q [$];

    initial begin
        for (int d = 0; d < 2; d++) begin
            nbits[d] = 0; last_rise[d] = 0; hi_start[d] = 0; ld_start[d] = 0;
            stab_err[d] = 0; per_err[d] = 0; hi_err[d] = 0; lw_err[d] = 0;
            ldclk_err[d] = 0; nbit_err[d] = 0; shreg[d] = '0;
            psclk[d] = 1'b0; pload[d] = 1'b0; pdout[d] = 1'b0;
        end
    end

    always @(negedge clk) begin
        int cd;
        cyc++;
        for (int d = 0; d < 2; d++) begin
            cd = (d == 0) ? 2 : 1;
            if (!rst_n) begin
                nbits[d] = 0; psclk[d] = 1'b0; pload[d] = 1'b0; pdout[d] = 1'b0;
            end else begin
                if (sclk[d] && !psclk[d]) begin
                    if (dout[d] !== pdout[d]) stab_err[d]++;
                    if (nbits[d] > 0 && cyc - last_rise[d] != 2 * cd) per_err[d]++;
                    last_rise[d] = cyc;
                    hi_start[d] = cyc;
                    shreg[d] = {shreg[d][14:0], dout[d]};
                    nbits[d]++;
                end
                if (sclk[d] && psclk[d] && dout[d] !== pdout[d]) stab_err[d]++;
                if (!sclk[d] && psclk[d] && cyc - hi_start[d] != cd) hi_err[d]++;
                if (load[d] && sclk[d]) ldclk_err[d]++;
                if (load[d] && !pload[d]) begin
                    if (nbits[d] != 16) nbit_err[d]++;
                    if (d == 0) begin fq0.push_back(shreg[d]); lt0.push_back(cyc); end
                    else begin fq1.push_back(shreg[d]); lt1.push_back(cyc); end
                    nbits[d] = 0;
                    ld_start[d] = cyc;
                end
                if (!load[d] && pload[d] && cyc - ld_start[d] != 2 * cd) lw_err[d]++;
                psclk[d] = sclk[d];
                pload[d] = load[d];
                pdout[d] = dout[d];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic int decode(input logic [7:0] s);
        for (int k = 0; k < 10; k++) if (SEG[k] == s) return k;
        return 15;
    endfunction

    task automatic push_init();
        exp_q.push_back(16'h0900); exp_q.push_back(16'h0A08); exp_q.push_back(16'h0B07);
        exp_q.push_back(16'h0C01); exp_q.push_back(16'h0F00);
    endtask

    task automatic push_refresh(input logic [23:0] v);
        logic [7:0] data;
        for (int i = 0; i < 8; i++) begin
            data = (i < 6) ? SEG[(v >> (20 - 4 * i)) & 24'hF] : 8'h00;
            exp_q.push_back(16'((i + 1) * 256) | {8'h00, data});
        end
    endtask

    task automatic check_frames(input int d, input int breaks, input string tag);
        logic [15:0] got [$];
        int          t [$];
        int          per;
        int          nb;
        if (d == 0) begin got = fq0; t = lt0; per = 72; end
        else begin got = fq1; t = lt1; per = 36; end
        chk({tag, "_count"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            chk($sformatf("%s_frame%0d", tag, i), {16'h0, got[i]}, {16'h0, exp_q[i]});
        nb = 0;
        for (int i = 1; i < t.size(); i++) if (t[i] - t[i-1] != per) nb++;
        chk({tag, "_spacing"}, nb, breaks);
        if (d == 0) begin fq0.delete(); lt0.delete(); end
        else begin fq1.delete(); lt1.delete(); end
        exp_q.delete();
    endtask

    // Counts negedges until dut0 goes idle; optional strobes and a mid-run i_bcd change at given counts.
    task automatic wait_idle(input int s1, input int s2, input int s3, input int chg_at,
                             input logic [23:0] chg_val, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            upd = (n == s1 || n == s2 || n == s3);
            if (n == chg_at) bcd = chg_val;
        end while (busy[0] && n < 3000);
    endtask

    function automatic logic [23:0] rand_bcd();
        logic [23:0] r;
        r = '0;
        for (int k = 0; k < 6; k++) r = {r[19:0], 4'($urandom_range(0, 11))};
        return r;
    endfunction

    initial begin
        int          n;
        int          dec;
        int          found;
        logic [23:0] rb;
        logic [23:0] rb1;

        rst_n = 1'b0; upd = 1'b0; upd1 = 1'b0; bcd = '0; bcd1 = '0;
        repeat (3) @(negedge clk);
        chk("rst_sclk", sclk[0], 0);
        chk("rst_dout", dout[0], 0);
        chk("rst_load", load[0], 0);
        chk("rst_busy", busy[0], 1);
        chk("rst_busy_cd1", busy[1], 1);

        rst_n = 1'b1;
        wait_idle(-1, -1, -1, -1, '0, n);
        chk("init_len", n, 361);
        push_init(); check_frames(0, 0, "init");
        push_init(); check_frames(1, 0, "init_cd1");

        bcd = 24'h115900; upd = 1'b1;
        wait_idle(-1, -1, -1, -1, '0, n);
        chk("ref115900_len", n, 577);
        dec = 0;
        if (fq0.size() >= 6) for (int i = 0; i < 6; i++) dec = dec * 10 + decode(fq0[i][7:0]);
        chk("display_115900", dec, 115900);
        push_refresh(24'h115900); check_frames(0, 0, "ref115900");

        bcd = 24'h235959; upd = 1'b1;
        wait_idle(-1, -1, -1, 200, 24'h000000, n);
        chk("snap_len", n, 577);
        push_refresh(24'h235959); check_frames(0, 0, "snap235959");

        bcd = 24'hAB0000; upd = 1'b1;
        wait_idle(-1, -1, -1, -1, '0, n);
        if (fq0.size() >= 2) begin
            chk("ab_digit0", fq0[0][7:0], 8'h00);
            chk("ab_digit1", fq0[1][7:0], 8'h00);
        end
        push_refresh(24'hAB0000); check_frames(0, 0, "abinvalid");

        for (int r = 0; r < 4; r++) begin
            rb = rand_bcd();
            bcd = rb; upd = 1'b1;
            wait_idle(-1, -1, -1, int'($urandom_range(2, 570)), rand_bcd(), n);
            chk($sformatf("rand%0d_len", r), n, 577);
            push_refresh(rb); check_frames(0, 0, $sformatf("rand%0d", r));
        end

        rb1 = rand_bcd();
        bcd1 = rb1; upd1 = 1'b1;
        @(negedge clk); upd1 = 1'b0; bcd1 = rand_bcd();
        repeat (400) @(negedge clk);
        push_refresh(rb1); check_frames(1, 0, "ref_cd1");

        rb = rand_bcd();
        bcd = rb; upd = 1'b1;
        wait_idle(576, -1, -1, -1, '0, n);
        chk("edge_len", n, 577);
        @(negedge clk);
        chk("edge_restart", busy[0], 1);
        wait_idle(-1, -1, -1, -1, '0, n);
        chk("edge_len2", n, 576);
        repeat (200) @(negedge clk);
        chk("edge_single", busy[0], 0);
        push_refresh(rb); push_refresh(rb); check_frames(0, 1, "edge");

        bcd = 24'h123456; upd = 1'b1;
        found = 0;
        for (int i = 0; i < 500 && found == 0; i++) begin
            @(negedge clk);
            upd = 1'b0;
            #1;
            if (nbits[0] == 9 && sclk[0]) found = 1;
        end
        chk("bit7_reached", found, 1);
        chk("bit7_sclk_high", sclk[0], 1);
        rst_n = 1'b0;
        #1;
        chk("async_sclk", sclk[0], 0);
        chk("async_dout", dout[0], 0);
        chk("async_load", load[0], 0);
        chk("async_busy", busy[0], 1);
        fq0.delete(); lt0.delete(); fq1.delete(); lt1.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_idle(20, 21, 300, -1, '0, n);
        chk("reinit_len", n, 361);
        @(negedge clk);
        chk("pending_start", busy[0], 1);
        wait_idle(-1, -1, -1, -1, '0, n);
        chk("pending_len", n, 576);
        repeat (300) @(negedge clk);
        chk("pending_single", busy[0], 0);
        push_init(); push_refresh(24'h123456); check_frames(0, 1, "reinit");
        push_init(); check_frames(1, 0, "reinit_cd1");

        for (int d = 0; d < 2; d++) begin
            chk($sformatf("din_stable_%0d", d), stab_err[d], 0);
            chk($sformatf("bit_period_%0d", d), per_err[d], 0);
            chk($sformatf("clk_high_%0d", d), hi_err[d], 0);
            chk($sformatf("load_width_%0d", d), lw_err[d], 0);
            chk($sformatf("clk_in_load_%0d", d), ldclk_err[d], 0);
            chk($sformatf("bits_per_frame_%0d", d), nbit_err[d], 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
